// File: rtl/dbus_pkg.sv
// dbus_pkg: shared definitions for the data-bus initiator.
//   - transfer size codes
//   - FSM state encoding
//   - memory-mapped peripheral addresses
//   - req_err(): request legality check done at handshake time
package dbus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RMW_RD = 2'b10,
        S_RMW_WR = 2'b11
    } state_t;

    localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED    = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI   = 32'h4000_0014;

    // 1 = request must be answered with an error and no bus cycle.
    // Sub-word stores are only legal when read-modify-write is available.
    function automatic logic req_err(input logic [1:0] size, input logic [1:0] off,
                                     input logic we, input logic rmw_en);
        case (size)
            SZ_BYTE: req_err = we & ~rmw_en;
            SZ_HALF: req_err = off[0] | (we & ~rmw_en);
            SZ_WORD: req_err = |off;
            default: req_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_lane.sv
// dbus_lane: combinational byte/halfword lane handling.
//   i_size, i_signed, i_off : latched request attributes
//   i_bus                   : word read from the bus
//   i_st                    : right-justified store data
//   o_ld                    : extracted and extended load value
//   o_merge                 : i_bus with the addressed lane replaced by i_st
module dbus_lane
    import dbus_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_bus,
    input  logic [31:0] i_st,
    output logic [31:0] o_ld,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_bus[7:0];
            2'd1:    w_byte = i_bus[15:8];
            2'd2:    w_byte = i_bus[23:16];
            default: w_byte = i_bus[31:24];
        endcase
        w_half = i_off[1] ? i_bus[31:16] : i_bus[15:0];
    end

    always_comb begin
        o_ld    = i_bus;
        o_merge = i_st;
        case (i_size)
            SZ_BYTE: begin
                o_ld    = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merge = i_bus;
                o_merge[{i_off, 3'b000} +: 8] = i_st[7:0];
            end
            SZ_HALF: begin
                o_ld    = {{16{i_signed & w_half[15]}}, w_half};
                o_merge = i_bus;
                o_merge[{i_off[1], 4'b0000} +: 16] = i_st[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dbus_master.sv
// dbus_master: pipeline-side initiator for the shared word-only data bus.
//   clk, reset(async, active low)
//   req_*  : valid/ready load/store request from MEM stage
//   resp_* : one-cycle completion pulse with load data / error flag
//   rd, wr, addr, wdata, rdata : bus; rdata is combinational from target
// Sub-word stores become a read then a write of the whole word; the
// sequence is not atomic against hardware-updated targets.
module dbus_master
    import dbus_pkg::*;
#(
    parameter logic RMW_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    state_t      r_state, w_next;
    logic        r_we, r_signed;
    logic [1:0]  r_size, r_off;
    logic [31:0] r_st, r_addr, r_wdata, r_resp_rdata;
    logic        r_resp_valid, r_resp_err;
    logic        w_hs, w_err;
    logic [31:0] w_ld, w_merge;

    assign w_hs  = req_valid & (r_state == S_IDLE);
    assign w_err = req_err(req_size, req_addr[1:0], req_we, RMW_EN);

    dbus_lane u_lane (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_off    (r_off),
        .i_bus    (rdata),
        .i_st     (r_st),
        .o_ld     (w_ld),
        .o_merge  (w_merge)
    );

    // Strobes decode from registered state only.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_hs && !w_err)
                    w_next = (req_we && req_size != SZ_WORD) ? S_RMW_RD : S_ACCESS;
            end
            S_ACCESS: begin
                rd     = ~r_we;
                wr     = r_we;
                w_next = S_IDLE;
            end
            S_RMW_RD: begin
                rd     = 1'b1;
                w_next = S_RMW_WR;
            end
            default: begin
                wr     = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= SZ_BYTE;
            r_off        <= 2'b00;
            r_st         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_we     <= req_we;
                            r_size   <= req_size;
                            r_signed <= req_signed;
                            r_off    <= req_addr[1:0];
                            r_st     <= req_wdata;
                            r_addr   <= {req_addr[31:2], 2'b00};
                            if (req_we && req_size == SZ_WORD)
                                r_wdata <= req_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_we ? 32'h0 : w_ld;
                end
                // r_wdata doubles as the merge register: the read word with
                // the target lane already replaced, driven during RMW_WR.
                S_RMW_RD: r_wdata <= w_merge;
                default: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
            endcase
        end
    end

    assign addr       = r_addr;
    assign wdata      = r_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dbus_master.sv
// tb_dbus_master: randomized + directed bench for dbus_master. A bus memory
// answers the DUT; a transaction-level model predicts every output per cycle.
module tb_dbus_master;
    import dbus_pkg::*;

    localparam int MAXC = 4096;

    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, rd, wr;
    logic [31:0] resp_rdata, addr, wdata, rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, req_signed0 = 1'b0;
    logic [1:0]  req_size0 = 2'b00;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic        req_ready0, resp_valid0, resp_err0, rd0, wr0;
    logic [31:0] resp_rdata0, addr0, wdata0;
    logic [31:0] rdata0 = 32'hDEAD_BEEF;

    dbus_master #(.RMW_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    dbus_master #(.RMW_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_size(req_size0), .req_signed(req_signed0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .rd(rd0), .wr(wr0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tfail(input string nm);
        vectors++;
        errs++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", nm, cyc);
    endtask

    // ---------------- bus memory (words 0..15 at 0x100, 16..21 peripherals)
    logic [31:0] mem [32];
    logic [31:0] mmem [32];

    function automatic int bidx(input logic [31:0] a);
        return a[30] ? 16 + int'(a[4:2]) : int'(a[5:2]);
    endfunction

    function automatic logic [31:0] ival(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    initial for (int i = 0; i < 32; i++) begin
        mem[i]  = ival(i);
        mmem[i] = ival(i);
    end

    always @(posedge clk) if (wr) mem[bidx(addr)] <= wdata;
    always_comb rdata = mem[bidx(addr)];

    // ---------------- reference model
    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input bit sg, input logic [1:0] off);
        logic [31:0] mask, v;
        int sh;
        if (sz == 2'b10) return w;
        mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
        v    = (w >> sh) & mask;
        if (sg && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    function automatic bit m_err(input bit we, input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'b11) || (sz == 2'b01 && off[0]) ||
               (sz == 2'b10 && off != 2'b00) || (we && sz != 2'b10 && 1'b0);
    endfunction

    bit          e_rd [MAXC], e_wr [MAXC], e_rv [MAXC], e_err [MAXC];
    logic [31:0] e_addr [MAXC], e_wdata [MAXC], e_rdata [MAXC];
    int          busy = 0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_rd", rd, 0);
            chk("rst_wr", wr, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_addr", addr, 0);
            chk("rst_wdata", wdata, 0);
            for (int k = cyc; k < cyc + 5 && k < MAXC; k++) begin
                e_rd[k] = 0; e_wr[k] = 0; e_rv[k] = 0; e_err[k] = 0;
            end
            busy = 0;
        end else if (cyc < MAXC - 4) begin
            chk("req_ready", req_ready, 32'(cyc >= busy));
            chk("rd", rd, e_rd[cyc]);
            chk("wr", wr, e_wr[cyc]);
            chk("resp_valid", resp_valid, e_rv[cyc]);
            if (e_rd[cyc] || e_wr[cyc]) chk("addr", addr, e_addr[cyc]);
            if (e_wr[cyc]) chk("wdata", wdata, e_wdata[cyc]);
            if (e_rv[cyc]) begin
                chk("resp_rdata", resp_rdata, e_rdata[cyc]);
                chk("resp_err", resp_err, e_err[cyc]);
            end
            if (e_wr[cyc]) mmem[bidx(e_addr[cyc])] = e_wdata[cyc];
            if (req_valid && cyc >= busy) begin
                automatic int n = cyc;
                automatic int ix = bidx(req_addr);
                automatic logic [31:0] wa = req_addr & 32'hFFFF_FFFC;
                if (m_err(req_we, req_size, req_addr[1:0])) begin
                    e_rv[n+1] = 1; e_err[n+1] = 1; e_rdata[n+1] = 0;
                    busy = n + 1;
                end else if (!req_we || req_size == 2'b10) begin
                    e_rd[n+1] = !req_we; e_wr[n+1] = req_we;
                    e_addr[n+1] = wa; e_wdata[n+1] = req_wdata;
                    e_rv[n+2] = 1; e_err[n+2] = 0;
                    e_rdata[n+2] = req_we ? 32'h0 :
                                   m_load(mmem[ix], req_size, req_signed, req_addr[1:0]);
                    busy = n + 2;
                end else begin
                    e_rd[n+1] = 1; e_addr[n+1] = wa;
                    e_wr[n+2] = 1; e_addr[n+2] = wa;
                    e_wdata[n+2] = m_merge(mmem[ix], req_size, req_addr[1:0], req_wdata);
                    e_rv[n+3] = 1; e_err[n+3] = 0; e_rdata[n+3] = 0;
                    busy = n + 3;
                end
            end
        end
    end

    // ---------------- driver
    task automatic do_req(input bit u, input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdv, output logic er, output int lat,
                          output int strobes);
        int hs;
        bit got;
        @(posedge clk); #1;
        if (u) begin
            req_we0 = we; req_size0 = sz; req_signed0 = sg; req_addr0 = a;
            req_wdata0 = wd; req_valid0 = 1'b1;
        end else begin
            req_we = we; req_size = sz; req_signed = sg; req_addr = a;
            req_wdata = wd; req_valid = 1'b1;
        end
        hs = -1; rdv = '0; er = 1'b0; lat = -1; strobes = 0; got = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (u ? req_ready0 : req_ready) begin hs = cyc; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        if (hs < 0) tfail("handshake");
        else begin
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                strobes += u ? int'(rd0) + int'(wr0) : int'(rd) + int'(wr);
                if (u ? resp_valid0 : resp_valid) begin
                    rdv = u ? resp_rdata0 : resp_rdata;
                    er  = u ? resp_err0 : resp_err;
                    lat = cyc - hs;
                    got = 1;
                    break;
                end
            end
            if (!got) tfail("response");
        end
    endtask

    logic [31:0] rv;
    logic        re;
    int          lt, sb, h1, h2;

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 reset = 1'b1;

        // word store / load to LED
        do_req(0, 1, SZ_WORD, 0, ADDR_LED, 32'h0000_00A5, rv, re, lt, sb);
        chk("sw_lat", 32'(lt), 2); chk("sw_strobes", 32'(sb), 1); chk("sw_rdata", rv, 0);
        do_req(0, 0, SZ_WORD, 0, ADDR_LED, 0, rv, re, lt, sb);
        chk("lw_led", rv, 32'h0000_00A5); chk("lw_err", re, 0); chk("lw_lat", 32'(lt), 2);

        // sub-word store via read-modify-write
        do_req(0, 1, SZ_WORD, 0, ADDR_LED, 32'h0000_1234, rv, re, lt, sb);
        do_req(0, 1, SZ_BYTE, 0, ADDR_LED + 1, 32'h0000_00FF, rv, re, lt, sb);
        chk("sb_lat", 32'(lt), 3); chk("sb_strobes", 32'(sb), 2); chk("sb_err", re, 0);
        do_req(0, 0, SZ_WORD, 0, ADDR_LED, 0, rv, re, lt, sb);
        chk("lw_led_merged", rv, 32'h0000_FF34);

        // lane extraction
        do_req(0, 1, SZ_WORD, 0, 32'h100, 32'h8070_F0FF, rv, re, lt, sb);
        do_req(0, 0, SZ_BYTE, 1, 32'h101, 0, rv, re, lt, sb); chk("lb_101", rv, 32'hFFFF_FFF0);
        do_req(0, 0, SZ_BYTE, 0, 32'h103, 0, rv, re, lt, sb); chk("lbu_103", rv, 32'h0000_0080);
        do_req(0, 0, SZ_HALF, 1, 32'h102, 0, rv, re, lt, sb); chk("lh_102", rv, 32'hFFFF_8070);
        do_req(0, 0, SZ_HALF, 0, 32'h100, 0, rv, re, lt, sb); chk("lhu_100", rv, 32'h0000_F0FF);

        // errors
        do_req(0, 0, SZ_WORD, 0, 32'h102, 0, rv, re, lt, sb);
        chk("lw_mis_err", re, 1); chk("lw_mis_lat", 32'(lt), 1); chk("lw_mis_strobes", 32'(sb), 0);
        do_req(0, 1, SZ_HALF, 0, 32'h103, 32'h55, rv, re, lt, sb);
        chk("sh_mis_err", re, 1); chk("sh_mis_lat", 32'(lt), 1); chk("sh_mis_strobes", 32'(sb), 0);
        do_req(0, 0, 2'b11, 0, 32'h100, 0, rv, re, lt, sb);
        chk("sz11_err", re, 1); chk("sz11_rdata", rv, 0); chk("sz11_lat", 32'(lt), 1);

        // no read-modify-write variant
        do_req(1, 1, SZ_BYTE, 0, ADDR_LED, 32'hFF, rv, re, lt, sb);
        chk("norm_sb_err", re, 1); chk("norm_sb_lat", 32'(lt), 1); chk("norm_sb_strobes", 32'(sb), 0);
        do_req(1, 0, SZ_WORD, 0, ADDR_LED, 0, rv, re, lt, sb);
        chk("norm_lw", rv, 32'hDEAD_BEEF); chk("norm_lw_lat", 32'(lt), 2);

        // back-to-back word loads with valid held
        @(posedge clk); #1;
        req_we = 0; req_size = SZ_WORD; req_addr = 32'h100; req_valid = 1;
        h1 = -1; h2 = -1;
        for (int t = 0; t < 10; t++) begin @(negedge clk); if (req_ready) begin h1 = cyc; break; end end
        @(posedge clk); #1; req_addr = ADDR_LED;
        for (int t = 0; t < 10; t++) begin @(negedge clk); if (req_ready) begin h2 = cyc; break; end end
        @(posedge clk); #1; req_valid = 0;
        if (h1 < 0 || h2 < 0) tfail("b2b_handshake");
        else chk("b2b_spacing", 32'(h2 - h1), 2);
        repeat (4) @(posedge clk);

        // reset during RMW_RD
        @(posedge clk); #1;
        req_we = 1; req_size = SZ_HALF; req_addr = 32'h104; req_wdata = 32'hBEEF; req_valid = 1;
        h1 = -1;
        for (int t = 0; t < 10; t++) begin @(negedge clk); if (req_ready) begin h1 = cyc; break; end end
        @(posedge clk); #1; req_valid = 0;
        if (h1 < 0) tfail("rst_handshake");
        chk("rmw_rd_active", rd, 1);
        #1 reset = 1'b0;
        #1 chk("rst_rd_drop", rd, 0); chk("rst_wr_none", wr, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        do_req(0, 0, SZ_WORD, 0, 32'h104, 0, rv, re, lt, sb);
        chk("rst_no_write", rv, 32'hC0DE_0001);

        // randomized traffic, checked per cycle by the model
        for (int i = 0; i < 300; i++) begin
            automatic logic [1:0] off = 2'($urandom_range(0, 3));
            automatic logic [31:0] a = ($urandom_range(0, 1) == 1)
                ? 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'(off)
                : ADDR_TH + 32'(4 * $urandom_range(0, 5)) + 32'(off);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, rv, re, lt, sb);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/dbus_master.md
Name: dbus_master

Overview:
CPU-side initiator for the shared data bus (rd, wr, addr, wdata, rdata) that serves the data memory and the memory-mapped peripherals (timer, LEDs, switches, digits at 0x4000_0000..0x4000_0014). It accepts load and store requests from the pipeline MEM stage through a valid/ready handshake and drives word-aligned bus cycles. Loads get byte and halfword lane extraction with sign or zero extension. Sub-word stores to the word-only bus are done as read-modify-write; misaligned requests are rejected with an error response.

Parameters:
RMW_EN, 1, 1 = sub-word stores use read-modify-write; 0 = sub-word stores complete with resp_err=1 and no bus activity.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline request present
req_ready  out  1  high only in IDLE; a request transfers when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  load sign-extend (byte/half only)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned/illegal access, valid with resp_valid
rd  out  1  bus read strobe
wr  out  1  bus write strobe
addr  out  32  bus address, always {a[31:2],2'b00}
wdata  out  32  bus write data
rdata  in  32  bus read data, combinational from target, sampled same cycle as rd

Behaviour:
- Reset (async, reset=0): state IDLE; rd=wr=0; addr=0; wdata=0; resp_valid=0; resp_rdata=0; resp_err=0. Any in-flight request is dropped and produces no response.
- States: IDLE, ACCESS, RMW_RD, RMW_WR. rd/wr decode from the state register only (no combinational path from req_*). addr/wdata are registered and hold their last value in IDLE.
- IDLE: req_ready=1. On handshake, the request is checked for errors:
  - Error when size=11, half with a[0]=1, word with a[1:0]!=0, or sub-word store with RMW_EN=0.
  - On error: stay IDLE; next cycle resp_valid=1, resp_err=1, resp_rdata=0; bus untouched.
- No error, load or word store: latch the request, go ACCESS.
- No error, byte/half store with RMW_EN=1: latch, go RMW_RD.
- ACCESS: rd=1 (load) or wr=1 (store, wdata=req_wdata). Capture the lane-extracted rdata, go IDLE. resp_valid pulses in the following cycle.
- RMW_RD: rd=1; capture rdata into the merge register; go RMW_WR.
- RMW_WR: wr=1; wdata = merge register with the target lane replaced. Byte lane k = a[1:0] takes bits 8k+7:8k (little-endian). Half lane = a[1]. Then go IDLE, with resp_valid in the next cycle.
- Latency from the handshake cycle N:
  - word access: bus cycle N+1, resp_valid N+2
  - sub-word store: rd N+1, wr N+2, resp N+3
  - error: resp N+1
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high (IDLE). Throughput is one word access per 2 cycles.
- Load extraction: byte = lane a[1:0]; half = lane a[1]. Extend with bit 7/15 when req_signed=1, else with zeros. Word loads ignore req_signed.
- Never rd and wr in the same cycle. resp_valid is never high for more than one consecutive cycle per request.
- RMW is not atomic: a hardware-updated target (e.g. timer TL) may change between RMW_RD and RMW_WR, and the merge uses the RMW_RD value. This is documented, intended behaviour.
- reset asserted in ACCESS/RMW_*: strobes drop immediately, no partial write issued afterwards.

Decomposition:
- Shared package dbus_pkg:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encodings S_IDLE, S_ACCESS, S_RMW_RD, S_RMW_WR
  - peripheral map constants: TH 0x4000_0000, TL 0x4000_0004, TCON 0x4000_0008, LED 0x4000_000C, SWITCH 0x4000_0010, DIGI 0x4000_0014
- One combinational sub-module, dbus_lane: inputs size, signed, a[1:0], bus word, store data; outputs the extracted/extended load value and the merged store word. The FSM and registers stay in dbus_master.

Test Plan:
- Word store 0x0000_00A5 to 0x4000_000C, then word load 0x4000_000C -> wr pulse at N+1 with addr=0x4000_000C, wdata=0xA5; LED register=0xA5; load resp_rdata=0x0000_00A5, resp_err=0.
- Peripheral LED=0x0000_1234 stub word; sb 0xFF at 0x4000_000D -> rd at N+1, wr at N+2 with wdata=0x0000_FF34, resp_valid at N+3.
- Memory word 0x8070_F0FF at 0x100: lb 0x101 signed -> 0xFFFF_FFF0; lbu 0x103 -> 0x0000_0080; lh 0x102 signed -> 0xFFFF_8070; lhu 0x100 -> 0x0000_F0FF.
- lw at 0x102, sh at 0x103, size=11 at 0x100 -> each resp_valid at N+1 with resp_err=1, rd=wr=0 throughout.
- RMW_EN=0: sb to 0x4000_000C -> resp_err=1, LED unchanged. Also pull reset low during RMW_RD -> rd drops immediately, no wr ever issued, no resp_valid.
- Two word loads with req_valid held high -> second accepted in the first's resp_valid cycle; responses at N+2 and N+4.
